// File: rtl/cycle_pkg.sv
// Shared widths, typedefs and FSM state encoding for the fork period meter.
package cycle_pkg;

  localparam int PERIOD_W = 24;
  localparam int REV_W    = 16;

  typedef logic [PERIOD_W-1:0] period_t;
  typedef logic [REV_W-1:0]    rev_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fork_state_e;

endpackage

// File: rtl/fork_debounce.sv
// Fork sensor conditioning: 2-flop synchronizer, optional debounce filter (FORK_DEBOUNCE_EN),
// and a single-cycle strobe on each 1-to-0 transition of the filtered level.
module fork_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic nfork,
  output logic fork_event
);

`ifdef FORK_DEBOUNCE_EN
  localparam bit DEBOUNCE_EN = 1'b1;
`else
  localparam bit DEBOUNCE_EN = 1'b0;
`endif

  // A zero hold count lets the filtered level follow the synchronizer with no extra delay.
  localparam int HOLD_CYCLES = DEBOUNCE_EN ? DEBOUNCE_CYCLES : 0;
  localparam int CNT_W       = $clog2(HOLD_CYCLES + 2);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(HOLD_CYCLES)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= nfork;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fork_event = level_q & ~level_d;

endmodule

// File: rtl/fork_period_meter.sv
// Wheel period meter: times the interval between fork events, hands it off over valid/ready,
// counts revolutions and detects a stopped wheel. Debounce is enabled by FORK_DEBOUNCE_EN.
module fork_period_meter
  import cycle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 4194303
) (
  input  logic                core_CLK,
  input  logic                core_nReset,
  input  logic                nfork,
  input  logic                clear,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  input  logic                period_ready,
  output logic [REV_W-1:0]    rev_count,
  output logic                stopped,
  output logic                overrun
);

  logic        fork_event;
  fork_state_e state_q,        state_d;
  period_t     cnt_q,          cnt_d;
  period_t     period_q,       period_d;
  logic        period_valid_q, period_valid_d;
  rev_t        rev_count_q,    rev_count_d;
  logic        overrun_q,      overrun_d;

  fork_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (core_CLK),
    .rst_n      (core_nReset),
    .nfork      (nfork),
    .fork_event (fork_event)
  );

  // NOTE: every signal gets a default at the top of the block, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    rev_count_d    = rev_count_q;
    overrun_d      = overrun_q;

    if (period_valid_q && period_ready) begin
      period_valid_d = 1'b0;
    end

    if (state_q == IDLE) begin
      cnt_d = '0;
      if (fork_event) begin
        state_d = RUN;
        cnt_d   = period_t'(1);
      end
    end else begin
      if (fork_event) begin
        period_d       = cnt_q;
        period_valid_d = 1'b1;
        cnt_d          = period_t'(1);
        // A capture in a transfer cycle is a clean hand-off, not an overwrite.
        if (period_valid_q && !period_ready) begin
          overrun_d = 1'b1;
        end
      end else if (cnt_q == period_t'(TIMEOUT_CYCLES)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (fork_event) begin
      rev_count_d = rev_count_q + 1'b1;
    end

    if (clear) begin
      rev_count_d = '0;
      overrun_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge
  // values; the combinational block above uses blocking ones.
  always_ff @(posedge core_CLK or negedge core_nReset) begin
    if (!core_nReset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      rev_count_q    <= '0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      rev_count_q    <= rev_count_d;
      overrun_q      <= overrun_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign rev_count    = rev_count_q;
  assign overrun      = overrun_q;
  assign stopped      = (state_q == IDLE);

endmodule

// File: tb/tb_fork_period_meter.sv
// Scoreboard bench for fork_period_meter: the driver pushes expected periods as it issues
// fork pulses, a monitor pops and compares on every valid/ready transfer.
module tb_fork_period_meter;

  localparam int DB = 16;
  localparam int TO = 5000;
  // Negedges from the nfork fall until rev_count shows the event: the strobe sits 2 (+DB)
  // cycles after the fall and the counters register it on the following edge.
`ifdef FORK_DEBOUNCE_EN
  localparam int EV_LAT = 3 + DB;
`else
  localparam int EV_LAT = 3;
`endif

  logic        core_CLK = 1'b0;
  logic        core_nReset;
  logic        nfork;
  logic        clear;
  logic [23:0] period;
  logic        period_valid;
  logic        period_ready;
  logic [15:0] rev_count;
  logic        stopped;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_fall = 0;
  int exp_q[$];
  int exp_p;

  fork_period_meter #(
    .DEBOUNCE_CYCLES (DB),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .core_CLK     (core_CLK),
    .core_nReset  (core_nReset),
    .nfork        (nfork),
    .clear        (clear),
    .period       (period),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .rev_count    (rev_count),
    .stopped      (stopped),
    .overrun      (overrun)
  );

  always #5 core_CLK = ~core_CLK;

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge core_CLK);
      cyc++;
    end
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick(1);
  endtask

  // Start a fork pulse now; optionally expect a period equal to the spacing from the last fall.
  task automatic fall(input bit push);
    if (push) exp_q.push_back(cyc - last_fall);
    last_fall = cyc;
    nfork = 1'b0;
  endtask

  task automatic fork_pulse(input int low, input int spacing, input bit push);
    fall(push);
    tick_to(last_fall + low);
    nfork = 1'b1;
    tick_to(last_fall + spacing);
  endtask

  // Inputs change at the negedge; 1 ns later they hold until the next active edge.
  always @(negedge core_CLK) begin
    #1;
    if (core_nReset && period_valid && period_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_period: got %0d, expected no transfer (cycle %0d)", period, cyc);
      end else begin
        exp_p = exp_q.pop_front();
        check("period_transfer", int'(period), exp_p);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    core_nReset  = 1'b0;
    nfork        = 1'b1;
    clear        = 1'b0;
    period_ready = 1'b1;
    tick(2);
    check("rst_period", int'(period), 0);
    check("rst_valid", int'(period_valid), 0);
    check("rst_rev", int'(rev_count), 0);
    check("rst_stopped", int'(stopped), 1);
    check("rst_overrun", int'(overrun), 0);
    core_nReset = 1'b1;
    tick(5);

    // Steady pulses: 65 low every 3277 cycles.
    for (int i = 0; i < 5; i++) begin
      fall(i > 0);
      tick_to(last_fall + EV_LAT - 1);
      check("steady_rev_before", int'(rev_count), i);
      tick(1);
      check("steady_rev", int'(rev_count), i + 1);
      check("steady_stopped", int'(stopped), 0);
      check("steady_valid", int'(period_valid), (i > 0) ? 1 : 0);
      if (i > 0) check("steady_period", int'(period), 3277);
      tick(1);
      check("steady_valid_pulse", int'(period_valid), 0);
      tick_to(last_fall + 65);
      nfork = 1'b1;
      tick_to(last_fall + 3277);
    end

    // Backpressure: captures of 1000 and 1200 while the consumer stalls.
    fork_pulse(65, 1000, 1'b1);
    period_ready = 1'b0;
    fork_pulse(65, 1200, 1'b0);
    check("bp_first_period", int'(period), 1000);
    check("bp_first_valid", int'(period_valid), 1);
    check("bp_first_overrun", int'(overrun), 0);
    fork_pulse(65, 300, 1'b1);
    check("bp_period", int'(period), 1200);
    check("bp_valid", int'(period_valid), 1);
    check("bp_overrun", int'(overrun), 1);
    period_ready = 1'b1;
    tick(1);
    check("bp_valid_after_xfer", int'(period_valid), 0);
    check("bp_overrun_sticky", int'(overrun), 1);
    tick(10);
    check("bp_overrun_still", int'(overrun), 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_overrun", int'(overrun), 0);
    check("clr_rev", int'(rev_count), 0);
    check("clr_period_kept", int'(period), 1200);
    check("clr_fsm_kept", int'(stopped), 0);

    // Timeout: two more events, then silence.
    fork_pulse(65, 1000, 1'b1);
    fork_pulse(65, 1000, 1'b1);
    tick_to(last_fall + EV_LAT + TO - 1);
    check("to_not_yet", int'(stopped), 0);
    tick(1);
    check("to_stopped", int'(stopped), 1);
    check("to_no_valid", int'(period_valid), 0);
    check("to_no_extra_period", exp_q.size(), 0);
    fork_pulse(65, 1000, 1'b0);
    check("to_rearm_stopped", int'(stopped), 0);
    check("to_rearm_rev", int'(rev_count), 3);
    check("to_rearm_valid", int'(period_valid), 0);

    // Reset 500 cycles after an event discards the partial interval.
    fall(1'b1);
    tick_to(last_fall + 65);
    nfork = 1'b1;
    tick_to(last_fall + EV_LAT + 500);
    core_nReset = 1'b0;
    #1;
    check("mid_rst_period", int'(period), 0);
    check("mid_rst_valid", int'(period_valid), 0);
    check("mid_rst_rev", int'(rev_count), 0);
    check("mid_rst_stopped", int'(stopped), 1);
    check("mid_rst_overrun", int'(overrun), 0);
    tick(1);
    core_nReset = 1'b1;
    tick(3);
    fork_pulse(65, 700, 1'b0);
    check("post_rst_arm_valid", int'(period_valid), 0);
    fork_pulse(65, 900, 1'b1);
    fork_pulse(65, 900, 1'b1);
    check("post_rst_rev", int'(rev_count), 3);

    // Wrap: preload rev_count just below the limit instead of issuing 65535 events.
    force dut.rev_count_q = 16'hFFFF;
    tick(1);
    release dut.rev_count_q;
    tick(1);
    check("wrap_preload", int'(rev_count), 65535);
    fork_pulse(65, 1000, 1'b1);
    check("wrap_rev", int'(rev_count), 0);
    fork_pulse(65, 1000, 1'b1);
    check("pre_clr_rev", int'(rev_count), 1);

    // Clear in the same cycle as an event.
    fall(1'b1);
    tick_to(last_fall + EV_LAT - 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_event_rev", int'(rev_count), 0);
    check("clr_event_period", int'(period), 1000);
    check("clr_event_valid", int'(period_valid), 1);
    tick_to(last_fall + 65);
    nfork = 1'b1;
    tick_to(last_fall + 1000);

`ifdef FORK_DEBOUNCE_EN
    // A 10-cycle glitch is filtered; a 20-cycle low gives one event at the fixed latency.
    nfork = 1'b0;
    tick(10);
    nfork = 1'b1;
    tick(40);
    check("db_glitch_rev", int'(rev_count), 0);
    fall(1'b1);
    tick_to(last_fall + EV_LAT - 1);
    check("db_rev_before", int'(rev_count), 0);
    tick(1);
    check("db_rev_at_latency", int'(rev_count), 1);
    tick_to(last_fall + 20);
    nfork = 1'b1;
    tick_to(last_fall + 100);
    check("db_single_event", int'(rev_count), 1);
`endif

    tick(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fork_period_meter.md
FORK_PERIOD_METER -- requirements
Module: fork_period_meter

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the number of consecutive stable samples required before the filtered fork level changes.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 4194303, meaning the number of cycles without a fork event after which the wheel is declared stopped.
REQ-003 The block SHALL have the following ports, one per line: name, direction, width, meaning.
  core_CLK      in   1   single clock; all logic is on its rising edge.
  core_nReset   in   1   asynchronous, active-low reset.
  nfork         in   1   fork sensor, active-low pulse; asynchronous to core_CLK.
  clear         in   1   synchronous clear of rev_count and overrun.
  period        out  24  clock cycles between the last two fork events.
  period_valid  out  1   period holds an unconsumed result.
  period_ready  in   1   the consumer accepts period.
  rev_count     out  16  fork events since reset or clear.
  stopped       out  1   no fork activity within the timeout.
  overrun       out  1   sticky flag; an unconsumed period was overwritten.

Function
REQ-004 nfork SHALL pass through a 2-flop synchronizer whose flops reset to 1.
REQ-005 A fork event SHALL be a 1-to-0 transition of the filtered level; it is a single-cycle internal strobe.
REQ-006 Event latency from the nfork fall SHALL be 2 cycles without debounce, or 2+DEBOUNCE_CYCLES cycles with debounce.
- This latency is constant, so period is unaffected by it.
REQ-007 The FSM SHALL have exactly two states, IDLE and RUN; reset enters IDLE.
REQ-008 The block SHALL behave as follows in IDLE:
- stopped=1;
- the interval counter is held at 0;
- an event moves the FSM to RUN, loads the counter with 1, increments rev_count, and emits no period.
REQ-009 The block SHALL behave as follows in RUN:
- the counter increments each cycle;
- an event captures the counter value into period, asserts period_valid, reloads the counter with 1, and increments rev_count;
- so for events at cycles t0 and t1, period = t1-t0.
REQ-010 In RUN, when the counter reaches TIMEOUT_CYCLES without an event, the FSM SHALL return to IDLE and emit no period; period and period_valid are left unchanged.
REQ-011 stopped SHALL be 0 exactly while the FSM is in RUN.
REQ-012 A transfer SHALL occur in a cycle where period_valid=1 and period_ready=1.
- period_valid stays high until a transfer.
- period holds its value while period_valid=1, unless overwritten per REQ-013.
REQ-013 A capture while period_valid=1 and period_ready=0 SHALL overwrite period, keep period_valid=1, and set overrun.
REQ-014 A capture in the same cycle as a transfer SHALL load the new period, keep period_valid=1, and leave overrun unchanged.
REQ-015 rev_count SHALL wrap from 65535 to 0.
REQ-016 clear SHALL zero rev_count and overrun and take priority over a same-cycle event or overrun set.
- That event still updates period and the FSM.
REQ-017 clear SHALL NOT affect period, period_valid, or FSM state.

Reset
REQ-018 On core_nReset low, the block SHALL immediately set:
- period=0, period_valid=0, rev_count=0, overrun=0, stopped=1;
- FSM=IDLE, counter=0, synchronizer and filtered level=1, debounce counter=0.
REQ-019 Reset asserted mid-measurement SHALL discard the partial interval; the first event after reset only arms RUN.

Configuration
REQ-020 With macro FORK_DEBOUNCE_EN defined, the filtered level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any glitch shorter than that is ignored and restarts the count.
REQ-021 Without FORK_DEBOUNCE_EN, the filtered level SHALL equal the synchronized input, and DEBOUNCE_CYCLES is unused.

Structure
REQ-022 A shared package cycle_pkg SHALL hold:
- constants PERIOD_W=24 and REV_W=16;
- typedefs period_t and rev_t;
- the FSM state enum fork_state_e {IDLE, RUN}.
REQ-023 Synchronizer plus debounce filter SHALL be one sub-module, fork_debounce; the FSM, counters, and handshake live in fork_period_meter.

Verification
REQ-024 The bench SHALL cover the following scenarios:
- Steady pulses: nfork low 65 cycles every 3277 cycles, period_ready=1 -> first event gives no period; each later event gives period=3277 and a one-cycle period_valid pulse; rev_count increments per event; stopped=0 after the first event.
- Backpressure: period_ready=0 across two captures of 1000 and 1200 -> period=1200, period_valid=1, overrun=1; asserting period_ready then clears period_valid; overrun stays 1 until clear.
- Timeout: with TIMEOUT_CYCLES=5000, pulses at period 1000 then none -> stopped=1 exactly 5000 cycles after the last event, no extra period; the next pulse re-arms without emitting a period.
- Debounce (FORK_DEBOUNCE_EN, DEBOUNCE_CYCLES=16): 10-cycle low glitch -> no event; 20-cycle low -> exactly one event, 18 cycles after the fall.
- Wrap/clear: 65536 events -> rev_count=0; clear coincident with an event -> rev_count=0 and period updated.
- Reset mid-interval: core_nReset pulsed 500 cycles after an event -> all outputs at reset values; the next two events yield period equal to their true spacing.
